// File: rtl/atm_pkg.sv
// Shared state and op-code encodings for the ATM session controller.
package atm_pkg;

  typedef logic [3:0] atm_state_t;

  localparam atm_state_t ST_IDLE    = 4'd0;
  localparam atm_state_t ST_CHECK   = 4'd1;
  localparam atm_state_t ST_PIN     = 4'd2;
  localparam atm_state_t ST_MENU    = 4'd3;
  localparam atm_state_t ST_WDRAW   = 4'd4;
  localparam atm_state_t ST_DEPOSIT = 4'd5;
  localparam atm_state_t ST_SHOWBAL = 4'd6;
  localparam atm_state_t ST_EJECT   = 4'd7;
  localparam atm_state_t ST_RETAIN  = 4'd8;

  localparam logic [1:0] OP_WDRAW = 2'b00;
  localparam logic [1:0] OP_DEP   = 2'b01;
  localparam logic [1:0] OP_BAL   = 2'b10;
  localparam logic [1:0] OP_EXIT  = 2'b11;

endpackage

// File: rtl/atm_balance_bank.sv
// Per-account balance registers with the subtract/add results and the
// insufficient-funds / overflow flags for the currently selected account.
module atm_balance_bank #(
  parameter int BAL_W    = 16,
  parameter int N_ACCT   = 4,
  parameter int INIT_BAL = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(N_ACCT)-1:0] i_idx,
  input  logic [BAL_W-1:0]          i_amt,
  input  logic                      i_we,
  input  logic [BAL_W-1:0]          i_wr_bal,
  output logic [BAL_W-1:0]          o_bal,
  output logic [BAL_W-1:0]          o_sub_bal,
  output logic [BAL_W-1:0]          o_add_bal,
  output logic                      o_insuf,
  output logic                      o_ovf
);

  logic [BAL_W-1:0] r_bal [N_ACCT];
  logic [BAL_W:0]   w_sum;

  assign o_bal     = r_bal[i_idx];
  assign o_insuf   = (i_amt > o_bal);
  assign o_sub_bal = o_bal - i_amt;
  assign w_sum     = {1'b0, o_bal} + {1'b0, i_amt};
  assign o_add_bal = w_sum[BAL_W-1:0];
  assign o_ovf     = w_sum[BAL_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ACCT; i++) r_bal[i] <= BAL_W'(INIT_BAL);
    end else if (i_we) begin
      r_bal[i_idx] <= i_wr_bal;
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM card-session FSM: IDLE wait card, CHECK validate, PIN entry, MENU op select,
// WDRAW/DEPOSIT take amount, SHOWBAL inquiry, EJECT/RETAIN one-cycle card pulse.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int PIN_W     = 4,
  parameter int BAL_W     = 16,
  parameter int N_ACCT    = 4,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 1023,
  parameter int INIT_BAL  = 100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      card_in,
  input  logic                      card_ok,
  input  logic [$clog2(N_ACCT)-1:0] acct_sel,
  input  logic                      pin_vld,
  input  logic [PIN_W-1:0]          pin,
  input  logic [PIN_W-1:0]          pin_ref,
  input  logic                      op_vld,
  input  logic [1:0]                op,
  input  logic                      amt_vld,
  input  logic [BAL_W-1:0]          amt,
  input  logic                      cancel,
  output logic [3:0]                state,
  output logic                      eject,
  output logic                      retain,
  output logic                      dispense,
  output logic [BAL_W-1:0]          disp_amt,
  output logic [BAL_W-1:0]          bal_out,
  output logic                      txn_ok,
  output logic                      txn_err
);

  localparam int              AW       = $clog2(N_ACCT);
  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]      TRY_MAX  = 3'(MAX_TRIES);

  atm_state_t       r_state, w_nxt_state;
  logic [AW-1:0]    r_acct;
  logic [2:0]       r_tries, w_tries_nxt;
  logic [TW-1:0]    r_timer;
  logic             r_eject, r_retain, r_disp, r_ok, r_err;
  logic [BAL_W-1:0] r_disp_amt, r_bal_out;

  logic             w_active, w_timed, w_timeout, w_strobe, w_acct_ld;
  logic             w_eject, w_retain, w_disp, w_ok, w_err, w_bal_ld, w_we;
  logic [BAL_W-1:0] w_bal_nxt, w_wr_bal, w_rd_bal, w_sub_bal, w_add_bal;
  logic             w_insuf, w_ovf;

  atm_balance_bank #(
    .BAL_W   (BAL_W),
    .N_ACCT  (N_ACCT),
    .INIT_BAL(INIT_BAL)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_idx    (r_acct),
    .i_amt    (amt),
    .i_we     (w_we),
    .i_wr_bal (w_wr_bal),
    .o_bal    (w_rd_bal),
    .o_sub_bal(w_sub_bal),
    .o_add_bal(w_add_bal),
    .o_insuf  (w_insuf),
    .o_ovf    (w_ovf)
  );

  assign w_active  = (r_state != ST_IDLE) && (r_state != ST_EJECT) && (r_state != ST_RETAIN);
  assign w_timed   = (r_state == ST_PIN) || (r_state == ST_MENU) ||
                     (r_state == ST_WDRAW) || (r_state == ST_DEPOSIT);
  assign w_timeout = w_timed && (r_timer == TMR_LAST);

  always_comb begin
    w_nxt_state = r_state;
    w_tries_nxt = r_tries;
    w_strobe    = 1'b0;
    w_acct_ld   = 1'b0;
    w_eject     = 1'b0;
    w_retain    = 1'b0;
    w_disp      = 1'b0;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_bal_ld    = 1'b0;
    w_bal_nxt   = r_bal_out;
    w_we        = 1'b0;
    w_wr_bal    = w_rd_bal;
    // Card removal silently abandons the session; cancel and timeout eject.
    if (w_active && !card_in) begin
      w_nxt_state = ST_IDLE;
    end else if (w_active && cancel) begin
      w_nxt_state = ST_EJECT;
    end else if (w_timeout) begin
      w_nxt_state = ST_EJECT;
    end else begin
      case (r_state)
        ST_IDLE: if (card_in) w_nxt_state = ST_CHECK;
        ST_CHECK: begin
          if (card_ok) begin
            w_nxt_state = ST_PIN;
            w_acct_ld   = 1'b1;
            w_tries_nxt = '0;
          end else begin
            w_nxt_state = ST_EJECT;
          end
        end
        ST_PIN: if (pin_vld) begin
          w_strobe = 1'b1;
          if (pin == pin_ref) begin
            w_nxt_state = ST_MENU;
          end else begin
            w_tries_nxt = r_tries + 3'd1;
            if (w_tries_nxt == TRY_MAX) w_nxt_state = ST_RETAIN;
          end
        end
        ST_MENU: if (op_vld) begin
          w_strobe = 1'b1;
          case (op)
            OP_WDRAW: w_nxt_state = ST_WDRAW;
            OP_DEP:   w_nxt_state = ST_DEPOSIT;
            OP_BAL:   w_nxt_state = ST_SHOWBAL;
            OP_EXIT:  w_nxt_state = ST_EJECT;
          endcase
        end
        ST_WDRAW: if (amt_vld) begin
          w_strobe    = 1'b1;
          w_nxt_state = ST_MENU;
          if (!w_insuf) begin
            w_we      = 1'b1;
            w_wr_bal  = w_sub_bal;
            w_disp    = 1'b1;
            w_ok      = 1'b1;
            w_bal_ld  = 1'b1;
            w_bal_nxt = w_sub_bal;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_DEPOSIT: if (amt_vld) begin
          w_strobe    = 1'b1;
          w_nxt_state = ST_MENU;
          if (!w_ovf) begin
            w_we      = 1'b1;
            w_wr_bal  = w_add_bal;
            w_ok      = 1'b1;
            w_bal_ld  = 1'b1;
            w_bal_nxt = w_add_bal;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_SHOWBAL: begin
          w_ok        = 1'b1;
          w_bal_ld    = 1'b1;
          w_bal_nxt   = w_rd_bal;
          w_nxt_state = ST_MENU;
        end
        ST_EJECT: begin
          w_eject     = 1'b1;
          w_nxt_state = ST_IDLE;
        end
        ST_RETAIN: begin
          w_retain    = 1'b1;
          w_nxt_state = ST_IDLE;
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_acct     <= '0;
      r_tries    <= '0;
      r_timer    <= '0;
      r_eject    <= 1'b0;
      r_retain   <= 1'b0;
      r_disp     <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
      r_disp_amt <= '0;
      r_bal_out  <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_tries  <= w_tries_nxt;
      if (w_acct_ld) r_acct <= acct_sel;
      if (!w_timed || w_strobe || (w_nxt_state != r_state)) r_timer <= '0;
      else                                                  r_timer <= r_timer + TW'(1);
      r_eject    <= w_eject;
      r_retain   <= w_retain;
      r_disp     <= w_disp;
      r_ok       <= w_ok;
      r_err      <= w_err;
      r_disp_amt <= w_disp ? amt : '0;
      if (w_bal_ld) r_bal_out <= w_bal_nxt;
    end
  end

  assign state    = r_state;
  assign eject    = r_eject;
  assign retain   = r_retain;
  assign dispense = r_disp;
  assign disp_amt = r_disp_amt;
  assign bal_out  = r_bal_out;
  assign txn_ok   = r_ok;
  assign txn_err  = r_err;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed test-plan scenarios plus randomized sessions, each cycle checked
// against a behavioural session model kept in this bench.
module tb_atm_session_ctrl;

  localparam int PIN_W     = 4;
  localparam int BAL_W     = 16;
  localparam int N_ACCT    = 4;
  localparam int MAX_TRIES = 3;
  localparam int TIMEOUT   = 1023;
  localparam int INIT_BAL  = 100;
  localparam int BAL_MAX   = (1 << BAL_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             card_in, card_ok, pin_vld, op_vld, amt_vld, cancel;
  logic [1:0]       acct_sel;
  logic [PIN_W-1:0] pin, pin_ref;
  logic [1:0]       op;
  logic [BAL_W-1:0] amt;
  logic [3:0]       state;
  logic             eject, retain, dispense, txn_ok, txn_err;
  logic [BAL_W-1:0] disp_amt, bal_out;

  int n_checks = 0;
  int n_fail   = 0;

  // model: session state by its spec encoding, balances as plain integers
  int m_state, m_acct, m_tries, m_quiet;
  int m_bal [N_ACCT];
  int e_bal_out, e_disp_amt;
  bit e_eject, e_retain, e_disp, e_ok, e_err;

  atm_session_ctrl #(
    .PIN_W(PIN_W), .BAL_W(BAL_W), .N_ACCT(N_ACCT),
    .MAX_TRIES(MAX_TRIES), .TIMEOUT(TIMEOUT), .INIT_BAL(INIT_BAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .card_in(card_in), .card_ok(card_ok),
    .acct_sel(acct_sel), .pin_vld(pin_vld), .pin(pin), .pin_ref(pin_ref),
    .op_vld(op_vld), .op(op), .amt_vld(amt_vld), .amt(amt), .cancel(cancel),
    .state(state), .eject(eject), .retain(retain), .dispense(dispense),
    .disp_amt(disp_amt), .bal_out(bal_out), .txn_ok(txn_ok), .txn_err(txn_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_acct = 0; m_tries = 0; m_quiet = 0;
    for (int i = 0; i < N_ACCT; i++) m_bal[i] = INIT_BAL;
    e_bal_out = 0; e_disp_amt = 0;
    e_eject = 0; e_retain = 0; e_disp = 0; e_ok = 0; e_err = 0;
  endtask

  task automatic model_step();
    bit active, timed, accepted;
    int nxt;
    active   = (m_state >= 1) && (m_state <= 6);
    timed    = (m_state >= 2) && (m_state <= 5);
    accepted = 0;
    nxt      = m_state;
    e_eject = 0; e_retain = 0; e_disp = 0; e_ok = 0; e_err = 0; e_disp_amt = 0;
    if (active && !card_in)                    nxt = 0;
    else if (active && cancel)                 nxt = 7;
    else if (timed && (m_quiet + 1 >= TIMEOUT)) nxt = 7;
    else begin
      case (m_state)
        0: if (card_in) nxt = 1;
        1: if (card_ok) begin nxt = 2; m_acct = int'(acct_sel); m_tries = 0; end
           else nxt = 7;
        2: if (pin_vld) begin
             accepted = 1;
             if (pin == pin_ref) nxt = 3;
             else begin
               m_tries++;
               if (m_tries >= MAX_TRIES) nxt = 8;
             end
           end
        3: if (op_vld) begin accepted = 1; nxt = 4 + int'(op); end
        4: if (amt_vld) begin
             accepted = 1; nxt = 3;
             if (int'(amt) <= m_bal[m_acct]) begin
               m_bal[m_acct] -= int'(amt);
               e_disp = 1; e_disp_amt = int'(amt); e_ok = 1; e_bal_out = m_bal[m_acct];
             end else e_err = 1;
           end
        5: if (amt_vld) begin
             accepted = 1; nxt = 3;
             if (m_bal[m_acct] + int'(amt) <= BAL_MAX) begin
               m_bal[m_acct] += int'(amt);
               e_ok = 1; e_bal_out = m_bal[m_acct];
             end else e_err = 1;
           end
        6: begin e_bal_out = m_bal[m_acct]; e_ok = 1; nxt = 3; end
        7: begin e_eject = 1; nxt = 0; end
        8: begin e_retain = 1; nxt = 0; end
        default: nxt = 0;
      endcase
    end
    if (nxt != m_state || accepted || !timed) m_quiet = 0;
    else m_quiet++;
    m_state = nxt;
  endtask

  task automatic compare_all();
    check_eq("state", state, m_state);
    check_eq("eject", eject, e_eject);
    check_eq("retain", retain, e_retain);
    check_eq("dispense", dispense, e_disp);
    if (e_disp) check_eq("disp_amt", disp_amt, e_disp_amt);
    check_eq("bal_out", bal_out, e_bal_out);
    check_eq("txn_ok", txn_ok, e_ok);
    check_eq("txn_err", txn_err, e_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_pin(input logic [PIN_W-1:0] p);
    pin = p; pin_vld = 1'b1; cycle(); pin_vld = 1'b0;
  endtask

  task automatic send_op(input logic [1:0] o);
    op = o; op_vld = 1'b1; cycle(); op_vld = 1'b0;
  endtask

  task automatic send_amt(input logic [BAL_W-1:0] a);
    amt = a; amt_vld = 1'b1; cycle(); amt_vld = 1'b0;
  endtask

  task automatic insert_card(input logic [1:0] a);
    card_in = 1'b1; card_ok = 1'b1; acct_sel = a;
    cycle(); cycle();
  endtask

  task automatic end_session();
    card_in = 1'b0; cycle(); cycle();
  endtask

  initial begin
    int k;
    card_in = 0; card_ok = 0; acct_sel = 0; pin_vld = 0; pin = 0;
    op_vld = 0; op = 0; amt_vld = 0; amt = 0; cancel = 0;
    pin_ref = 4'd5;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check_eq("reset_disp_amt", disp_amt, 0);
    rst_n = 1'b1;

    // withdraw 40 then an over-balance 61 on account 2
    insert_card(2'd2);
    send_pin(pin_ref);
    send_op(2'b00);
    send_amt(16'd40);
    check_eq("wd40_dispense", dispense, 1);
    check_eq("wd40_disp_amt", disp_amt, 40);
    check_eq("wd40_bal_out", bal_out, 60);
    check_eq("wd40_ok", txn_ok, 1);
    send_op(2'b00);
    send_amt(16'd61);
    check_eq("wd61_err", txn_err, 1);
    check_eq("wd61_dispense", dispense, 0);
    send_op(2'b10);
    cycle();
    check_eq("showbal_acct2", bal_out, 60);
    end_session();

    // three wrong PINs retain the card
    insert_card(2'd0);
    repeat (3) send_pin(4'd9);
    check_eq("retain_state", state, 8);
    card_in = 1'b0;
    cycle();
    check_eq("retain_pulse", retain, 1);
    check_eq("retain_idle", state, 0);

    // deposit overflow, then a fitting deposit, on untouched account 1
    insert_card(2'd1);
    send_pin(pin_ref);
    send_op(2'b01);
    send_amt(16'd65500);
    check_eq("dep_ovf_err", txn_err, 1);
    check_eq("dep_ovf_menu", state, 3);
    send_op(2'b01);
    send_amt(16'd20);
    check_eq("dep20_ok", txn_ok, 1);
    check_eq("dep20_bal_out", bal_out, 120);

    // now idle in MENU: eject must appear TIMEOUT+1 cycles after entry
    k = 0;
    do begin cycle(); k++; end while (!eject && k < TIMEOUT + 20);
    check_eq("timeout_cycle", k, TIMEOUT + 1);
    end_session();

    // cancel on the same edge as an amount in WDRAW
    insert_card(2'd3);
    send_pin(pin_ref);
    send_op(2'b00);
    cancel = 1'b1; amt = 16'd10; amt_vld = 1'b1;
    cycle();
    cancel = 1'b0; amt_vld = 1'b0;
    check_eq("cancel_state", state, 7);
    check_eq("cancel_no_disp", dispense, 0);
    cycle();
    check_eq("cancel_eject", eject, 1);
    cycle(); cycle();
    send_pin(pin_ref);
    send_op(2'b10);
    cycle();
    check_eq("cancel_bal_kept", bal_out, 100);

    // asynchronous reset mid-withdrawal, then account 2 back to INIT_BAL
    send_op(2'b00);
    acct_sel = 2'd2;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_state", state, 0);
    check_eq("arst_bal_out", bal_out, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(); cycle();
    send_pin(pin_ref);
    send_op(2'b10);
    cycle();
    check_eq("arst_acct2_bal", bal_out, INIT_BAL);
    end_session();

    // randomized sessions
    for (int c = 0; c < 4000; c++) begin
      card_in  = ($urandom_range(0, 99) < 97);
      card_ok  = ($urandom_range(0, 99) < 85);
      acct_sel = 2'($urandom_range(0, N_ACCT - 1));
      pin_vld  = ($urandom_range(0, 99) < 30);
      pin      = $urandom_range(0, 1) ? pin_ref : 4'($urandom_range(0, 15));
      op_vld   = ($urandom_range(0, 99) < 30);
      op       = 2'($urandom_range(0, 3));
      amt_vld  = ($urandom_range(0, 99) < 35);
      amt      = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(65400, 65535))
                                             : 16'($urandom_range(0, 160));
      cancel   = ($urandom_range(0, 99) < 2);
      cycle();
    end
    pin_vld = 0; op_vld = 0; amt_vld = 0; cancel = 0;
    end_session();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
